// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle RISC-V main control unit and the ALU decoder.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTE_R = 4'd6,
    S_EXECUTE_I = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
  localparam logic [1:0] RESULT_MEMDATA   = 2'b01;
  localparam logic [1:0] RESULT_ALURESULT = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and enable from the current state.
module main_control_fsm
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       is_imm,
  output logic       illegal_instr
);

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECUTE_R;
          OP_I:              state_d = S_EXECUTE_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:    state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:     state_d = S_FETCH;
      S_MEMWRITE:  if (mem_ready) state_d = S_FETCH;
      S_EXECUTE_R: state_d = S_ALUWB;
      S_EXECUTE_I: state_d = S_ALUWB;
      S_ALUWB:     state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_ALUWB;
      S_ILLEGAL:   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = ADR_PC;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RESULT_ALUOUT;
    alu_op        = ALU_OP_ADD;
    is_imm        = 1'b0;
    illegal_instr = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        adr_src    = ADR_PC;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_OP_ADD;
        result_src = RESULT_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      // Branch target is precomputed into ALUOut while the opcode is decoded.
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_ADD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = ADR_ALUOUT;
      end
      S_MEMWB: begin
        result_src = RESULT_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = ADR_ALUOUT;
      end
      S_EXECUTE_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_OP_RTYPE;
      end
      S_EXECUTE_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_ITYPE;
        is_imm    = 1'b1;
      end
      S_ALUWB: begin
        result_src = RESULT_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_SUB;
        result_src = RESULT_ALUOUT;
        if (funct3 == F3_BEQ)      pc_write = zero;
        else if (funct3 == F3_BNE) pc_write = ~zero;
        else                       illegal_instr = 1'b1;
      end
      // ALUWB afterwards writes OldPC+4 computed here into rd.
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_OP_ADD;
        result_src = RESULT_ALUOUT;
        pc_write   = 1'b1;
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default: ;
    endcase
    // Suppress every side effect while reset is held, even in FETCH with mem_ready high.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: per-cycle vector table plus reset corner sequences,
// with expected output words queued on drive and compared on sample.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       is_imm, illegal_instr;

  main_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .is_imm(is_imm),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // {req,wr,adr,ir,pc,rw,a[1:0],b[1:0],rs[1:0],op[1:0],imm,ill}
  logic [16:0] outv;
  assign outv = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, result_src, alu_op, is_imm, illegal_instr};

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        mr;
    logic [16:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [16:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [16:0] ev(input logic req, input logic wr, input logic adr,
                                     input logic ir, input logic pc, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] rs, input logic [1:0] op,
                                     input logic imm, input logic ill);
    return {req, wr, adr, ir, pc, rw, a, b, rs, op, imm, ill};
  endfunction

  function automatic logic [16:0] e_fetch(input logic mr);
    return ev(1, 0, 0, mr, mr, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0, 0);
  endfunction
  function automatic logic [16:0] e_branch(input logic pc, input logic ill);
    return ev(0, 0, 0, 0, pc, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0, ill);
  endfunction

  logic [16:0] E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE;
  logic [16:0] E_EXEC_R, E_EXEC_I, E_ALUWB, E_JAL, E_ILLEGAL, E_RESET;

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic mr, input logic [16:0] e);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.z = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_pop();
    sb_t it;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      it = sb.pop_front();
      tests++;
      if (outv !== it.exp) begin
        fails++;
        $display("FAIL %s: got %05h expected %05h", it.name, outv, it.exp);
      end
    end
  endtask

  task automatic step(input vec_t v);
    sb_t it;
    @(negedge clk);
    opcode = v.op; funct3 = v.f3; zero = v.z; mem_ready = v.mr;
    it.name = v.name; it.exp = v.exp;
    sb.push_back(it);
    #1;
    check_pop();
  endtask

  task automatic expect_now(input string nm, input logic [16:0] e);
    sb_t it;
    it.name = nm; it.exp = e;
    sb.push_back(it);
    #1;
    check_pop();
  endtask

  initial begin
    E_DECODE   = ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    E_MEMADR   = ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    E_MEMREAD  = ev(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    E_MEMWB    = ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0);
    E_MEMWRITE = ev(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    E_EXEC_R   = ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0, 0);
    E_EXEC_I   = ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b11, 1, 0);
    E_ALUWB    = ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    E_JAL      = ev(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
    E_ILLEGAL  = ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
    E_RESET    = ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0, 0);

    // R-type, zero wait states: 4 cycles
    add("r_fetch",   7'b0110011, 3'd0, 0, 1'b1,      e_fetch(1'b1));
    add("r_decode",  7'b0110011, 3'd0, 0, rnd_bit(), E_DECODE);
    add("r_exec",    7'b0110011, 3'd0, 0, rnd_bit(), E_EXEC_R);
    add("r_aluwb",   7'b0110011, 3'd0, 0, rnd_bit(), E_ALUWB);
    // I-type
    add("i_fetch",   7'b0010011, 3'd0, 0, 1'b1,      e_fetch(1'b1));
    add("i_decode",  7'b0010011, 3'd0, 0, rnd_bit(), E_DECODE);
    add("i_exec",    7'b0010011, 3'd0, 0, rnd_bit(), E_EXEC_I);
    add("i_aluwb",   7'b0010011, 3'd0, 0, rnd_bit(), E_ALUWB);
    // lw with two wait cycles in MEMREAD: 7 cycles
    add("lw_fetch",  7'b0000011, 3'd2, 0, 1'b1,      e_fetch(1'b1));
    add("lw_decode", 7'b0000011, 3'd2, 0, rnd_bit(), E_DECODE);
    add("lw_memadr", 7'b0000011, 3'd2, 0, rnd_bit(), E_MEMADR);
    add("lw_rd_w0",  7'b0000011, 3'd2, 0, 1'b0,      E_MEMREAD);
    add("lw_rd_w1",  7'b0000011, 3'd2, 0, 1'b0,      E_MEMREAD);
    add("lw_rd_go",  7'b0000011, 3'd2, 0, 1'b1,      E_MEMREAD);
    add("lw_memwb",  7'b0000011, 3'd2, 0, rnd_bit(), E_MEMWB);
    // sw with one fetch wait and one write wait
    add("sw_fetch_w",7'b0100011, 3'd2, 0, 1'b0,      e_fetch(1'b0));
    add("sw_fetch",  7'b0100011, 3'd2, 0, 1'b1,      e_fetch(1'b1));
    add("sw_decode", 7'b0100011, 3'd2, 0, rnd_bit(), E_DECODE);
    add("sw_memadr", 7'b0100011, 3'd2, 0, rnd_bit(), E_MEMADR);
    add("sw_wr_w",   7'b0100011, 3'd2, 0, 1'b0,      E_MEMWRITE);
    add("sw_wr_go",  7'b0100011, 3'd2, 0, 1'b1,      E_MEMWRITE);
    // branches
    add("beq1_fetch",7'b1100011, 3'b000, 1, 1'b1,    e_fetch(1'b1));
    add("beq1_dec",  7'b1100011, 3'b000, 1, 1'b0,    E_DECODE);
    add("beq_taken", 7'b1100011, 3'b000, 1, 1'b0,    e_branch(1'b1, 1'b0));
    add("beq0_fetch",7'b1100011, 3'b000, 0, 1'b1,    e_fetch(1'b1));
    add("beq0_dec",  7'b1100011, 3'b000, 0, 1'b1,    E_DECODE);
    add("beq_not",   7'b1100011, 3'b000, 0, 1'b1,    e_branch(1'b0, 1'b0));
    add("bne0_fetch",7'b1100011, 3'b001, 0, 1'b1,    e_fetch(1'b1));
    add("bne0_dec",  7'b1100011, 3'b001, 0, 1'b0,    E_DECODE);
    add("bne_taken", 7'b1100011, 3'b001, 0, 1'b0,    e_branch(1'b1, 1'b0));
    add("bne1_fetch",7'b1100011, 3'b001, 1, 1'b1,    e_fetch(1'b1));
    add("bne1_dec",  7'b1100011, 3'b001, 1, 1'b0,    E_DECODE);
    add("bne_not",   7'b1100011, 3'b001, 1, 1'b0,    e_branch(1'b0, 1'b0));
    add("bbad_fetch",7'b1100011, 3'b100, 1, 1'b1,    e_fetch(1'b1));
    add("bbad_dec",  7'b1100011, 3'b100, 1, 1'b0,    E_DECODE);
    add("b_illegal", 7'b1100011, 3'b100, 1, 1'b0,    e_branch(1'b0, 1'b1));
    // jal
    add("jal_fetch", 7'b1101111, 3'd0, 0, 1'b1,      e_fetch(1'b1));
    add("jal_dec",   7'b1101111, 3'd0, 0, rnd_bit(), E_DECODE);
    add("jal_jal",   7'b1101111, 3'd0, 0, rnd_bit(), E_JAL);
    add("jal_aluwb", 7'b1101111, 3'd0, 0, rnd_bit(), E_ALUWB);
    // unsupported opcode
    add("ill_fetch", 7'b1111111, 3'd0, 0, 1'b1,      e_fetch(1'b1));
    add("ill_dec",   7'b1111111, 3'd0, 0, 1'b1,      E_DECODE);
    add("ill_state", 7'b1111111, 3'd0, 0, 1'b1,      E_ILLEGAL);
    add("ill_back",  7'b1111111, 3'd0, 0, 1'b0,      e_fetch(1'b0));

    mem_ready = 1'b1;
    #2;
    expect_now("reset_outputs", E_RESET);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    // the FETCH self-loop consumes this edge; first vector steps from FETCH

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset asserted mid-MEMWRITE with mem_ready low
    step('{"rs_fetch",  7'b0100011, 3'd2, 1'b0, 1'b1, e_fetch(1'b1)});
    step('{"rs_decode", 7'b0100011, 3'd2, 1'b0, 1'b0, E_DECODE});
    step('{"rs_memadr", 7'b0100011, 3'd2, 1'b0, 1'b0, E_MEMADR});
    step('{"rs_memwr",  7'b0100011, 3'd2, 1'b0, 1'b0, E_MEMWRITE});
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    expect_now("rs_async", E_RESET);
    @(posedge clk);
    expect_now("rs_held", E_RESET);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    step('{"rs_refetch", 7'b0100011, 3'd2, 1'b0, 1'b1, e_fetch(1'b1)});
    step('{"rs_redec",   7'b0100011, 3'd2, 1'b0, 1'b0, E_DECODE});
    step('{"rs_readr",   7'b0100011, 3'd2, 1'b0, 1'b0, E_MEMADR});

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, limit 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
